// File: rtl/tile_sequencer.sv
// tile_sequencer: per-tile instruction generator for the systolic-array core.
// Each start pulse runs weight fetch, weight load, activation execute and psum
// drain. The sequencer presents one registered 34-bit instruction per cycle.
// Optional drain watchdog: define SEQ_TIMEOUT_EN (err is tied low otherwise).
module tile_sequencer #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_w  = 11,
   parameter int len_w   = 11,
   parameter int timeout = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [addr_w-1:0]    x_wbase,
   input  logic [addr_w-1:0]    x_abase,
   input  logic [addr_w-1:0]    p_base,
   input  logic [len_w-1:0]     len,
   input  logic                 acc_en,
   input  logic                 ofifo_valid,
   output logic [2*addr_w+11:0] inst,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [2:0] {S_IDLE, S_WFETCH, S_WLOAD, S_EXEC, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic              acc;
      logic              cen_p;
      logic              wen_p;
      logic [addr_w-1:0] a_p;
      logic              cen_x;
      logic              wen_x;
      logic [addr_w-1:0] a_x;
      logic              ofifo_rd;
      logic              ififo_wr;
      logic              ififo_rd;
      logic              l0_rd;
      logic              l0_wr;
      logic              execute;
      logic              load;
   } inst_t;

   localparam inst_t INST_IDLE = '{acc: 1'b0, cen_p: 1'b1, wen_p: 1'b1, a_p: '0,
                                   cen_x: 1'b1, wen_x: 1'b1, a_x: '0,
                                   ofifo_rd: 1'b0, ififo_wr: 1'b0, ififo_rd: 1'b0,
                                   l0_rd: 1'b0, l0_wr: 1'b0, execute: 1'b0, load: 1'b0};

   // Counter is wide enough for len + 2 flush cycles and for col + row.
   localparam int CNT_W = len_w + 2;
   localparam logic [CNT_W-1:0] N_COL    = CNT_W'(col);
   localparam logic [CNT_W-1:0] N_FLUSH  = CNT_W'(col + 2);
   localparam logic [CNT_W-1:0] N_SETTLE = CNT_W'(col + row);

   if (col < 1 || row < 0 || timeout < 2 || CNT_W <= addr_w) begin : g_param_check
      $error("tile_sequencer: unsupported parameter combination");
   end

   state_t            state_q;
   inst_t             inst_q;
   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  pcnt_q;
   logic [1:0]        rd_sr_q;
   logic [addr_w-1:0] wbase_q;
   logic [addr_w-1:0] abase_q;
   logic [addr_w-1:0] pbase_q;
   logic [len_w-1:0]  len_q;
   logic              acc_q;

   logic [CNT_W-1:0]  len_x;
   logic [CNT_W-1:0]  ex_end;
   logic [CNT_W-1:0]  in_flight;
   logic              drain_act;
   logic              wd_fire;

   assign len_x     = CNT_W'(len_q);
   assign ex_end    = len_x + CNT_W'(2);
   // Psums already written plus the one read from the ofifo but not yet written.
   assign in_flight = pcnt_q + CNT_W'(inst_q.ofifo_rd);
   assign drain_act = (state_q == S_EXEC) || (state_q == S_DRAIN);

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(timeout + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout - 1);

   logic [WD_W-1:0] wd_q;
   logic            err_q;

   assign wd_fire = (state_q == S_DRAIN) && !inst_q.ofifo_rd &&
                    (wd_q == WD_LAST) && (pcnt_q != len_x);

   // Drain watchdog: counts DRAIN cycles since the last ofifo read; err is sticky until start.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q != S_DRAIN || inst_q.ofifo_rd) begin
            wd_q <= '0;
         end else if (!wd_fire) begin
            wd_q <= wd_q + WD_W'(1);
         end
         if (state_q == S_IDLE && start) begin
            err_q <= 1'b0;
         end else if (wd_fire) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign wd_fire = 1'b0;
   assign err     = 1'b0;
`endif

   // Main sequencer: phase FSM, counters, read-strobe pipeline and the registered instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         inst_q  <= INST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         rd_sr_q <= '0;
         wbase_q <= '0;
         abase_q <= '0;
         pbase_q <= '0;
         len_q   <= '0;
         acc_q   <= 1'b0;
      end else begin
         // NOTE: every field starts from its idle value each cycle and the later
         // non-blocking assignments below override individual fields; the last
         // scheduled update wins, so ordering within this block is the priority.
         inst_q       <= INST_IDLE;
         inst_q.l0_wr <= rd_sr_q[1];
         rd_sr_q      <= {rd_sr_q[0], 1'b0};
         done_q       <= 1'b0;

         if (drain_act) begin
            if (inst_q.ofifo_rd) begin
               inst_q.acc   <= acc_q;
               inst_q.cen_p <= 1'b0;
               inst_q.wen_p <= 1'b0;
               inst_q.a_p   <= pbase_q + pcnt_q[addr_w-1:0];
               pcnt_q       <= pcnt_q + CNT_W'(1);
            end
            if (ofifo_valid && (in_flight < len_x)) begin
               inst_q.ofifo_rd <= 1'b1;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  wbase_q      <= x_wbase;
                  abase_q      <= x_abase;
                  pbase_q      <= p_base;
                  len_q        <= len;
                  acc_q        <= acc_en;
                  busy_q       <= 1'b1;
                  pcnt_q       <= '0;
                  cnt_q        <= CNT_W'(1);
                  inst_q.cen_x <= 1'b0;
                  inst_q.a_x   <= x_wbase;
                  rd_sr_q[0]   <= 1'b1;
                  state_q      <= S_WFETCH;
               end
            end
            S_WFETCH: begin
               if (cnt_q < N_COL) begin
                  inst_q.cen_x <= 1'b0;
                  inst_q.a_x   <= wbase_q + cnt_q[addr_w-1:0];
                  rd_sr_q[0]   <= 1'b1;
                  cnt_q        <= cnt_q + CNT_W'(1);
               end else if (cnt_q < N_FLUSH) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  inst_q.l0_rd <= 1'b1;
                  inst_q.load  <= 1'b1;
                  cnt_q        <= CNT_W'(1);
                  state_q      <= S_WLOAD;
               end
            end
            S_WLOAD: begin
               if (cnt_q < N_COL) begin
                  inst_q.l0_rd <= 1'b1;
                  inst_q.load  <= 1'b1;
                  cnt_q        <= cnt_q + CNT_W'(1);
               end else if (cnt_q < N_SETTLE) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else if (len_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  inst_q.cen_x <= 1'b0;
                  inst_q.a_x   <= abase_q;
                  rd_sr_q[0]   <= 1'b1;
                  cnt_q        <= CNT_W'(1);
                  state_q      <= S_EXEC;
               end
            end
            S_EXEC: begin
               inst_q.l0_rd   <= rd_sr_q[1];
               inst_q.execute <= rd_sr_q[1];
               if (cnt_q < len_x) begin
                  inst_q.cen_x <= 1'b0;
                  inst_q.a_x   <= abase_q + cnt_q[addr_w-1:0];
                  rd_sr_q[0]   <= 1'b1;
                  cnt_q        <= cnt_q + CNT_W'(1);
               end else if (cnt_q < ex_end) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pcnt_q == len_x || wd_fire) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer: directed bench for tile_sequencer. Expected instructions
// are built per cycle from the tile timeline (reads at cycles 1..col, loads
// from col+3, activation reads from 2*col+row+3), counted from the start edge.
module tb_tile_sequencer;

   localparam int ROW      = 8;
   localparam int COL      = 8;
   localparam int AW       = 11;
   localparam int LW       = 11;
   localparam int TMO      = 16;
   localparam int LD_FIRST = COL + 3;
   localparam int EX_FIRST = 2 * COL + ROW + 3;
   localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] x_wbase;
   logic [AW-1:0] x_abase;
   logic [AW-1:0] p_base;
   logic [LW-1:0] len;
   logic          acc_en;
   logic          ofifo_valid;
   logic [33:0]   inst;
   logic          busy;
   logic          done;
   logic          err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tile_sequencer #(.row(ROW), .col(COL), .addr_w(AW), .len_w(LW), .timeout(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .x_wbase(x_wbase), .x_abase(x_abase),
      .p_base(p_base), .len(len), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [33:0] mk_inst(input logic rd, input logic [10:0] xa,
                                           input logic pw, input logic [10:0] pa, input logic acc,
                                           input logic ofrd, input logic l0rd, input logic l0wr,
                                           input logic ex, input logic ld);
      logic [33:0] v;
      v = INST_IDLE;
      if (rd) begin
         v[19]    = 1'b0;
         v[17:7]  = xa;
      end
      if (pw) begin
         v[33]    = acc;
         v[32]    = 1'b0;
         v[31]    = 1'b0;
         v[30:20] = pa;
      end
      v[6] = ofrd;
      v[3] = l0rd;
      v[2] = l0wr;
      v[1] = ex;
      v[0] = ld;
      return v;
   endfunction

   function automatic logic exp_rd(input int n, input logic [10:0] ln);
      return (n >= 1 && n <= COL) || (n >= EX_FIRST && n < EX_FIRST + int'(ln));
   endfunction

   // Runs one tile from a start pulse and checks inst/busy/done/err on every cycle.
   // vmask: ofifo_valid per cycle; pwmask: cycles expected to carry a pmem write.
   task automatic run_tile(input string tag, input logic [10:0] wb, input logic [10:0] ab,
                           input logic [10:0] pb, input logic [10:0] ln, input logic ac,
                           input logic [63:0] vmask, input logic [63:0] pwmask,
                           input int done_n, input int err_n, input int restart_n, input int ncyc);
      int          k;
      logic        rd, pw, ld, ex, l0w;
      logic [10:0] xa, pa;
      logic [33:0] exp_inst;
      x_wbase     = wb;
      x_abase     = ab;
      p_base      = pb;
      len         = ln;
      acc_en      = ac;
      ofifo_valid = 1'b0;
      start       = 1'b1;
      k           = 0;
      for (int n = 1; n <= ncyc; n++) begin
         step();
         start = (n == restart_n);
         if (n == 1) begin
            // Scramble the config ports: the tile must use the latched values.
            x_wbase = 11'd333;
            x_abase = 11'd555;
            p_base  = 11'd777;
            len     = 11'd9;
            acc_en  = ~ac;
         end
         ofifo_valid = vmask[n];
         rd  = exp_rd(n, ln);
         xa  = (n <= COL) ? wb + 11'(n - 1) : ab + 11'(n - EX_FIRST);
         l0w = (n > 2) && exp_rd(n - 2, ln);
         ld  = (n >= LD_FIRST) && (n < LD_FIRST + COL);
         ex  = (n >= EX_FIRST + 2) && (n < EX_FIRST + 2 + int'(ln));
         pw  = pwmask[n];
         pa  = pb + 11'(k);
         if (pw) k++;
         exp_inst = mk_inst(rd, xa, pw, pa, ac, pwmask[n+1], ld | ex, l0w, ex, ld);
         check($sformatf("%s inst n%0d", tag, n), inst, exp_inst);
         check($sformatf("%s busy n%0d", tag, n), busy, n < done_n);
         check($sformatf("%s done n%0d", tag, n), done, n == done_n);
         check($sformatf("%s err n%0d", tag, n), err, (err_n != 0) && (n >= err_n));
      end
      ofifo_valid = 1'b0;
   endtask

   initial begin
      logic [63:0] vm;
      logic [63:0] pm;
      reset       = 1'b1;
      start       = 1'b0;
      x_wbase     = '0;
      x_abase     = '0;
      p_base      = '0;
      len         = '0;
      acc_en      = 1'b0;
      ofifo_valid = 1'b0;
      repeat (3) step();
      check("reset inst", inst, INST_IDLE);
      check("reset busy", busy, 1'b0);
      reset = 1'b0;
      for (int n = 0; n < 10; n++) begin
         step();
         check($sformatf("idle inst c%0d", n), inst, INST_IDLE);
         check($sformatf("idle busy c%0d", n), busy, 1'b0);
         check($sformatf("idle done c%0d", n), done, 1'b0);
         check($sformatf("idle err c%0d", n), err, 1'b0);
      end

      // len = 0 with a second start while busy: no execute, single done after WLOAD.
      vm = (64'd1 << 10) | (64'd1 << 20);
      run_tile("len0", 11'd5, 11'd9, 11'd3, 11'd0, 1'b1, vm, 64'd0, EX_FIRST, 0, 5, 32);

`ifdef SEQ_TIMEOUT_EN
      // Drain watchdog: no psums, DRAIN spans cycles 31..46, done and err on 47.
      run_tile("tmo", 11'd0, 11'd40, 11'd0, 11'd2, 1'b0, 64'd0, 64'd0, 47, 47, -1, 50);
      step();
      check("tmo err sticky", err, 1'b1);
`endif

      // Main tile: activations 100..103, psums to 20..23 with acc, one back-to-back burst.
      vm = (64'd1 << 30) | (64'd1 << 32) | (64'd1 << 33) | (64'd1 << 34) | (64'd1 << 35) | (64'd1 << 36);
      pm = (64'd1 << 32) | (64'd1 << 34) | (64'd1 << 35) | (64'd1 << 36);
      run_tile("main", 11'd0, 11'd100, 11'd20, 11'd4, 1'b1, vm, pm, 37, 0, -1, 42);

      // Address wrap on weights, activations and psums.
      vm = (64'd1 << 31) | (64'd1 << 32) | (64'd1 << 33) | (64'd1 << 34) | (64'd1 << 37) | (64'd1 << 40);
      pm = (64'd1 << 33) | (64'd1 << 34) | (64'd1 << 35) | (64'd1 << 36);
      run_tile("wrap", 11'd2044, 11'd2046, 11'd2046, 11'd4, 1'b0, vm, pm, 37, 0, -1, 42);

      // Reset in the middle of EXEC.
      x_wbase = 11'd0;
      x_abase = 11'd100;
      p_base  = 11'd20;
      len     = 11'd4;
      acc_en  = 1'b1;
      start   = 1'b1;
      step();
      start = 1'b0;
      repeat (27) step();
      check("rst pre inst", inst, mk_inst(1'b1, 11'd101, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("rst pre busy", busy, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst inst", inst, INST_IDLE);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      for (int n = 0; n < 8; n++) begin
         step();
         check($sformatf("post rst inst c%0d", n), inst, INST_IDLE);
         check($sformatf("post rst busy c%0d", n), busy, 1'b0);
         check($sformatf("post rst done c%0d", n), done, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Instruction generator for the systolic-array core; drives the core's 34-bit inst bus each cycle.
- Sequences one tile per start pulse:
  - weight fetch xmem->L0
  - weight load into the PE array
  - activation stream + execute
  - psum drain ofifo->pmem, with optional accumulate
- Sits between the testbench/host control and core; replaces hand-written instruction vectors.

Parameters:
- row, 8, PE array rows (activation lanes)
- col, 8, PE array columns; number of weight vectors per tile
- addr_w, 11, xmem/pmem address width
- len_w, 11, activation-count width
- timeout, 1024, drain watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle tile start request
- x_wbase  in  addr_w  xmem base address of the col weight vectors
- x_abase  in  addr_w  xmem base address of the activation vectors
- p_base  in  addr_w  pmem base address for psum writes
- len  in  len_w  number of activation vectors (0..2047)
- acc_en  in  1  psum writes set the acc bit (accumulate into pmem)
- ofifo_valid  in  1  core output FIFO has a psum vector
- inst  out  34  registered core instruction:
  - [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at tile completion
- err  out  1  sticky watchdog error, cleared by start

Behaviour:
- Clock/reset: one clock clk; reset synchronous active-high. All outputs registered.
- Reset values:
  - inst = INST_IDLE = 34'h1_800C_0000 (CEN_pmem = WEN_pmem = CEN_xmem = WEN_xmem = 1, all else 0)
  - busy = 0, done = 0, err = 0
  - state IDLE; counters and read pipeline cleared
- Fixed fields: ififo_wr and ififo_rd are always 0. Every field not driven in a state holds its INST_IDLE value.
- Address arithmetic: all addresses are base + counter, modulo 2^addr_w (wrap permitted, no error).
- Read pipeline:
  - xmem read = CEN_xmem 0, WEN_xmem 1.
  - Data reaches core l0_in 2 cycles after the address cycle (SRAM read + l0_in register).
  - A 2-deep shift register of the read strobe drives l0_wr: l0_wr is high exactly 2 cycles after each xmem read cycle.
- FSM states:
  - IDLE
    - inst = INST_IDLE.
    - start -> latch all config, clear err, go WFETCH.
    - start is ignored while busy.
  - WFETCH
    - col cycles of xmem read at x_wbase + k, k = 0..col-1.
    - Then 2 flush cycles so the last l0_wr issues.
    - -> WLOAD.
  - WLOAD
    - l0_rd = 1, load = 1 for col cycles.
    - Then row idle cycles (weights propagate).
    - -> EXEC; go straight to DONE if len = 0.
  - EXEC
    - len cycles of xmem read at x_abase + i.
    - l0_rd = 1 and execute = 1 asserted in lockstep with l0_wr (2-cycle delay).
    - After the last l0_wr -> DRAIN.
  - DRAIN
    - Waits until pcnt = len -> DONE.
  - DONE
    - done = 1 for one cycle, busy drops in the same cycle, -> IDLE.
- Psum drain (active in EXEC and DRAIN):
  - Cycle t, ofifo_valid = 1 and pcnt + pending < len: ofifo_rd = 1.
  - Cycle t+1: CEN_pmem = 0, WEN_pmem = 0, A_pmem = p_base + pcnt, acc = acc_en; pcnt increments.
  - Back-to-back valid cycles yield back-to-back pmem writes.
  - Excess ofifo_valid beyond len is not read.
- Simultaneous events: a pmem write and an xmem read may share a cycle; the fields are independent.
- Reset mid-operation:
  - Next cycle inst = INST_IDLE, busy = 0, no done pulse.
  - Pending l0_wr and pmem writes are discarded.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - In DRAIN, a counter resets on each ofifo_rd.
  - If it reaches timeout: err = 1, done pulses, FSM -> IDLE, and pmem writes stop.
- Undefined:
  - No watchdog; err is tied 0.
  - DRAIN waits indefinitely.

Test Plan:
- Reset then idle 10 cycles -> inst = 34'h1_800C_0000, busy = 0, done = 0 throughout.
- start, x_wbase = 0, col = 8 -> A_xmem 0..7 on 8 consecutive read cycles; l0_wr high on cycles 2..9 relative to first read; then 8 cycles of l0_rd = load = 1.
- len = 4, x_abase = 100, p_base = 20, acc_en = 1, ofifo_valid pulsed 4 times -> A_xmem 100..103; pmem writes to 20..23 with acc = 1, each one cycle after ofifo_rd; one done pulse.
- Wrap: x_abase = 2046, len = 4 -> A_xmem 2046, 2047, 0, 1.
- len = 0 -> no execute, no pmem writes; done right after WLOAD. A start while busy is ignored, so only one done.
- Reset asserted mid-EXEC -> inst = INST_IDLE next cycle, busy = 0, no done.
- SEQ_TIMEOUT_EN with timeout = 16, ofifo_valid held 0 in DRAIN -> err = 1 and done after 16 cycles; err cleared by the next start.
